game_sequencer: RTL and testbench
=================================

# game_sequencer

Central game controller for the volcano flight game. It sequences play from IDLE through PLAY, HIT and OVER, and produces the movement strobe and `game_over` level that drive the plane, lava and mountain movers. It also runs bounding-box collision checks between the plane and the three obstacles, and owns the lives counter and score counter.

## Interface
- `FRAME_DIV`, 4: frame ticks per movement step (1..15)
- `LIVES`, 3: lives loaded at game start (1..3)
- `HIT_FRAMES`, 32: frames of invulnerability after a hit (1..63)
- `PLANE_X`, 100: fixed left x of plane; `PLANE_W`, 32; `PLANE_H`, 16
- `LAVA_W`, 16; `LAVA_H`, 16; `MTN_W`, 40; `MTN_H`, 80: obstacle box sizes
- `clk` in 1: system clock; one clock only
- `reset` in 1: synchronous, active-high reset
- `frame_tick` in 1: one-cycle pulse per video frame
- `start` in 1: level, player start button
- `plane_y` in 10: plane top y
- `lava_x`, `lava_y` in 10 each: lava drop top-left
- `mountain1_x`, `mountain1_y`, `mountain2_x`, `mountain2_y` in 10 each: mountain top-left
- `obstacle_passed` in 1: one-cycle pulse from a mover when an obstacle wraps
- `step_en` out 1: one-cycle movement strobe to all movers
- `game_over` out 1: level; movers freeze while high
- `state` out 2: IDLE=0, PLAY=1, HIT=2, OVER=3
- `lives` out 2: remaining lives
- `score` out 8: saturating score
- `flash` out 1: plane blink enable, for the renderer

## Operation
- **Reset:** `state`=IDLE, `lives`=0, `score`=0, `step_en`=0, `game_over`=1, `flash`=0. The frame divider and hit timer clear.
- **IDLE:** `game_over`=1. A rising edge of `start` loads `lives`=LIVES and `score`=0, then moves to PLAY. Start must be edge-detected with one registered copy, so holding `start` does not restart.
- **PLAY:** `game_over`=0.
  - The divider counts `frame_tick`. On the tick where the count reaches FRAME_DIV-1, `step_en` pulses for one cycle and the divider returns to 0.
  - On the cycle after `step_en`, the box overlap test runs against all three obstacles. Any overlap is a hit.
- **Overlap rule:** boxes A and B overlap iff Ax < Bx+Bw, Bx < Ax+Aw, Ay < By+Bh and By < Ay+Ah. Compute all sums at 11 bits, with no wrap.
- **Hit:**
  - If `lives`=1: `lives` goes to 0 and the state moves to OVER.
  - Otherwise: `lives` decrements, the state moves to HIT, and the hit timer loads HIT_FRAMES.
- **HIT:**
  - `game_over`=0 and `step_en` keeps running, so play continues.
  - Collisions are ignored.
  - `flash` toggles every 4 frame ticks.
  - The timer decrements on each `frame_tick`. At 0 the state returns to PLAY and `flash`=0.
- **OVER:** `game_over`=1, `step_en`=0, and `score` is held. A rising edge of `start` goes to IDLE, not directly to PLAY.
- **Score:** `obstacle_passed` adds 1 in PLAY and HIT only, saturating at 255. A pulse that coincides with the hit into OVER still counts.
- **Simultaneous events:** `frame_tick` coinciding with the collision-check cycle is impossible by construction, because ticks are one cycle and the check falls on the cycle after `step_en`. If `start` arrives in PLAY or HIT it is ignored.
- **Mid-game reset:** `reset` wins over every event in the same cycle and returns all outputs to their reset values.

## Timing
- `step_en` is registered and asserted in the cycle after the qualifying `frame_tick`.
- The collision check uses the positions the movers present one cycle after `step_en`. The state and `lives` update on the following edge, giving 2 cycles of latency from `step_en`.
- `game_over` and `state` are registered and change on the same edge.
- IDLE→PLAY takes effect 1 cycle after the `start` rising edge is detected.

## Structure
- Shared package `game_pkg`:
  - state encoding constants,
  - screen bounds (top 40, bottom 400, left 120),
  - object size constants, which the movers and renderer reuse.
- One sub-module, `box_overlap`: a combinational 11-bit AABB test instantiated three times, once each for lava, mountain1 and mountain2.
- The FSM, frame divider, hit timer, lives and score logic live in the top module.

## Test plan
- **Step rate:** reset, pulse `start`, then apply 8 `frame_tick`s with FRAME_DIV=4 → exactly 2 `step_en` pulses, each 1 cycle long, and `game_over`=0.
- **Single hit:** in PLAY, set `plane_y`=180, `lava_x`=110, `lava_y`=185, then `step_en` → 2 cycles later `state`=HIT, `lives`=2, and `flash` toggles over the next 8 ticks.
- **Invulnerability:** during HIT, hold the same overlap for HIT_FRAMES ticks → `lives` stays 2, then `state` returns to PLAY. The next `step_en` → `lives`=1.
- **Game over:** with `lives`=1, apply an overlap at mountain2 (`mountain2_x`=120, `mountain2_y`=150, `plane_y`=180) → `state`=OVER, `game_over`=1, `lives`=0, and `step_en` stays 0 for 10 ticks.
- **Score:**
  - 300 `obstacle_passed` pulses in PLAY → `score`=255.
  - Pulses in OVER → no change.
  - `start` in OVER → IDLE; the next `start` → PLAY with `score`=0.
- **Reset mid-game:** assert `reset` in HIT with `frame_tick` and `obstacle_passed` high → next cycle `state`=IDLE, `score`=0, `lives`=0, `game_over`=1.

Source files
------------

// File: rtl/game_pkg.sv
// Shared constants for the volcano flight game: state encoding, screen bounds and
// object box sizes reused by the sequencer, movers and renderer.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HIT  = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    localparam int SCREEN_TOP    = 40;
    localparam int SCREEN_BOTTOM = 400;
    localparam int SCREEN_LEFT   = 120;

    localparam int DEF_PLANE_X = 100;
    localparam int DEF_PLANE_W = 32;
    localparam int DEF_PLANE_H = 16;
    localparam int DEF_LAVA_W  = 16;
    localparam int DEF_LAVA_H  = 16;
    localparam int DEF_MTN_W   = 40;
    localparam int DEF_MTN_H   = 80;

    // Widen a 10-bit coordinate so position+size sums cannot wrap.
    function automatic logic [10:0] ext11(input logic [9:0] v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/box_overlap.sv
// Combinational axis-aligned bounding-box overlap test between box A and box B,
// evaluated at 11 bits so edge sums near the screen limit stay exact.
module box_overlap
    import game_pkg::*;
#(
    parameter int AW = DEF_PLANE_W,
    parameter int AH = DEF_PLANE_H,
    parameter int BW = DEF_LAVA_W,
    parameter int BH = DEF_LAVA_H
) (
    input  logic [9:0] i_ax,
    input  logic [9:0] i_ay,
    input  logic [9:0] i_bx,
    input  logic [9:0] i_by,
    output logic       o_hit
);

    logic w_xOverlap;
    logic w_yOverlap;

    assign w_xOverlap = (ext11(i_ax) < (ext11(i_bx) + 11'(BW))) &&
                        (ext11(i_bx) < (ext11(i_ax) + 11'(AW)));
    assign w_yOverlap = (ext11(i_ay) < (ext11(i_by) + 11'(BH))) &&
                        (ext11(i_by) < (ext11(i_ay) + 11'(AH)));
    assign o_hit      = w_xOverlap && w_yOverlap;

endmodule

// File: rtl/game_sequencer.sv
// Central game controller: IDLE/PLAY/HIT/OVER sequencing, movement strobe,
// collision checks against the three obstacles, lives and saturating score.
module game_sequencer
    import game_pkg::*;
#(
    parameter int FRAME_DIV  = 4,
    parameter int LIVES      = 3,
    parameter int HIT_FRAMES = 32,
    parameter int PLANE_X    = DEF_PLANE_X,
    parameter int PLANE_W    = DEF_PLANE_W,
    parameter int PLANE_H    = DEF_PLANE_H,
    parameter int LAVA_W     = DEF_LAVA_W,
    parameter int LAVA_H     = DEF_LAVA_H,
    parameter int MTN_W      = DEF_MTN_W,
    parameter int MTN_H      = DEF_MTN_H
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [9:0] plane_y,
    input  logic [9:0] lava_x,
    input  logic [9:0] lava_y,
    input  logic [9:0] mountain1_x,
    input  logic [9:0] mountain1_y,
    input  logic [9:0] mountain2_x,
    input  logic [9:0] mountain2_y,
    input  logic       obstacle_passed,
    output logic       step_en,
    output logic       game_over,
    output logic [1:0] state,
    output logic [1:0] lives,
    output logic [7:0] score,
    output logic       flash
);

    state_t     r_state, w_nextState;
    logic       r_startQ;
    logic [3:0] r_div, w_nextDiv;
    logic       r_step, w_nextStep;
    logic       r_chk;
    logic [5:0] r_hitTimer, w_nextHitTimer;
    logic [1:0] r_flashCnt, w_nextFlashCnt;
    logic       r_flash, w_nextFlash;
    logic [1:0] r_lives, w_nextLives;
    logic [7:0] r_score, w_nextScore;
    logic       r_gameOver, w_nextGameOver;

    logic       w_startRise;
    logic       w_active;
    logic       w_hitLava, w_hitMtn1, w_hitMtn2, w_hit;

    assign w_startRise = start && !r_startQ;
    assign w_active    = (r_state == ST_PLAY) || (r_state == ST_HIT);

    box_overlap #(.AW(PLANE_W), .AH(PLANE_H), .BW(LAVA_W), .BH(LAVA_H)) u_lava (
        .i_ax(10'(PLANE_X)), .i_ay(plane_y), .i_bx(lava_x), .i_by(lava_y), .o_hit(w_hitLava)
    );
    box_overlap #(.AW(PLANE_W), .AH(PLANE_H), .BW(MTN_W), .BH(MTN_H)) u_mtn1 (
        .i_ax(10'(PLANE_X)), .i_ay(plane_y), .i_bx(mountain1_x), .i_by(mountain1_y), .o_hit(w_hitMtn1)
    );
    box_overlap #(.AW(PLANE_W), .AH(PLANE_H), .BW(MTN_W), .BH(MTN_H)) u_mtn2 (
        .i_ax(10'(PLANE_X)), .i_ay(plane_y), .i_bx(mountain2_x), .i_by(mountain2_y), .o_hit(w_hitMtn2)
    );

    assign w_hit = w_hitLava || w_hitMtn1 || w_hitMtn2;

    always_comb begin
        w_nextState     = r_state;
        w_nextDiv       = r_div;
        w_nextStep      = 1'b0;
        w_nextHitTimer  = r_hitTimer;
        w_nextFlashCnt  = r_flashCnt;
        w_nextFlash     = r_flash;
        w_nextLives     = r_lives;
        w_nextScore     = r_score;

        if (w_active && frame_tick) begin
            if (r_div == 4'(FRAME_DIV - 1)) begin
                w_nextDiv  = 4'd0;
                w_nextStep = 1'b1;
            end else begin
                w_nextDiv  = r_div + 4'd1;
            end
        end

        // Passes still score on the cycle the final hit moves us to OVER.
        if (w_active && obstacle_passed && (r_score != 8'hFF))
            w_nextScore = r_score + 8'd1;

        case (r_state)
            ST_IDLE: begin
                if (w_startRise) begin
                    w_nextLives = 2'(LIVES);
                    w_nextScore = 8'd0;
                    w_nextDiv   = 4'd0;
                    w_nextState = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (r_chk && w_hit) begin
                    if (r_lives == 2'd1) begin
                        w_nextLives = 2'd0;
                        w_nextState = ST_OVER;
                    end else begin
                        w_nextLives    = r_lives - 2'd1;
                        w_nextState    = ST_HIT;
                        w_nextHitTimer = 6'(HIT_FRAMES);
                        w_nextFlashCnt = 2'd0;
                        w_nextFlash    = 1'b0;
                    end
                end
            end
            ST_HIT: begin
                if (frame_tick) begin
                    w_nextFlashCnt = r_flashCnt + 2'd1;
                    if (r_flashCnt == 2'd3)
                        w_nextFlash = !r_flash;
                    w_nextHitTimer = r_hitTimer - 6'd1;
                    if (r_hitTimer == 6'd1) begin
                        w_nextState = ST_PLAY;
                        w_nextFlash = 1'b0;
                    end
                end
            end
            ST_OVER: begin
                if (w_startRise)
                    w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase

        w_nextGameOver = (w_nextState == ST_IDLE) || (w_nextState == ST_OVER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_startQ   <= 1'b0;
            r_div      <= 4'd0;
            r_step     <= 1'b0;
            r_chk      <= 1'b0;
            r_hitTimer <= 6'd0;
            r_flashCnt <= 2'd0;
            r_flash    <= 1'b0;
            r_lives    <= 2'd0;
            r_score    <= 8'd0;
            r_gameOver <= 1'b1;
        end else begin
            r_state    <= w_nextState;
            r_startQ   <= start;
            r_div      <= w_nextDiv;
            r_step     <= w_nextStep;
            r_chk      <= r_step;
            r_hitTimer <= w_nextHitTimer;
            r_flashCnt <= w_nextFlashCnt;
            r_flash    <= w_nextFlash;
            r_lives    <= w_nextLives;
            r_score    <= w_nextScore;
            r_gameOver <= w_nextGameOver;
        end
    end

    assign step_en   = r_step;
    assign game_over = r_gameOver;
    assign state     = r_state;
    assign lives     = r_lives;
    assign score     = r_score;
    assign flash     = r_flash;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: steps, hits, invulnerability, game over,
// score saturation and mid-game reset, with hand-computed expectations.
module tb_game_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       start;
    logic [9:0] plane_y;
    logic [9:0] lava_x, lava_y;
    logic [9:0] mountain1_x, mountain1_y;
    logic [9:0] mountain2_x, mountain2_y;
    logic       obstacle_passed;
    logic       step_en;
    logic       game_over;
    logic [1:0] state;
    logic [1:0] lives;
    logic [7:0] score;
    logic       flash;

    int testCount = 0;
    int failCount = 0;
    int stepCount = 0;
    int stepConsec = 0;
    logic prevStep = 1'b0;

    game_sequencer dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
        .plane_y(plane_y), .lava_x(lava_x), .lava_y(lava_y),
        .mountain1_x(mountain1_x), .mountain1_y(mountain1_y),
        .mountain2_x(mountain2_x), .mountain2_y(mountain2_y),
        .obstacle_passed(obstacle_passed),
        .step_en(step_en), .game_over(game_over), .state(state),
        .lives(lives), .score(score), .flash(flash)
    );

    always #5 clk = ~clk;

    // One clock, then settle; tracks strobe count and back-to-back strobes.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (step_en === 1'b1) begin
            stepCount++;
            if (prevStep) stepConsec++;
        end
        prevStep = step_en;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Frame tick followed by enough idle cycles for strobe and collision to settle.
    task automatic applyStimulus(input int nTicks);
        for (int i = 0; i < nTicks; i++) begin
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
            cyc();
            cyc();
            cyc();
        end
    endtask

    task automatic passPulses(input int n);
        for (int i = 0; i < n; i++) begin
            obstacle_passed = 1'b1;
            cyc();
            obstacle_passed = 1'b0;
            cyc();
        end
    endtask

    task automatic pressStart();
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; start = 1'b0; obstacle_passed = 1'b0;
        plane_y = 10'd300;
        lava_x = 10'd500; lava_y = 10'd0;
        mountain1_x = 10'd800; mountain1_y = 10'd0;
        mountain2_x = 10'd800; mountain2_y = 10'd0;
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        checkOutput("reset_state", state, 0);
        checkOutput("reset_lives", lives, 0);
        checkOutput("reset_score", score, 0);
        checkOutput("reset_step", step_en, 0);
        checkOutput("reset_gameover", game_over, 1);
        checkOutput("reset_flash", flash, 0);

        // Held start enters PLAY once.
        start = 1'b1;
        cyc();
        checkOutput("start_state", state, 1);
        checkOutput("start_lives", lives, 3);
        checkOutput("start_gameover", game_over, 0);
        cyc(); cyc();
        start = 1'b0;
        cyc();
        checkOutput("start_held_state", state, 1);

        stepCount = 0; stepConsec = 0;
        applyStimulus(8);
        checkOutput("step_count", stepCount, 2);
        checkOutput("step_width", stepConsec, 0);
        checkOutput("step_gameover", game_over, 0);

        passPulses(10);
        checkOutput("score_play10", score, 10);

        // First hit on lava.
        plane_y = 10'd180; lava_x = 10'd110; lava_y = 10'd185;
        applyStimulus(3);
        checkOutput("prehit_state", state, 1);
        applyStimulus(1);
        checkOutput("hit_state", state, 2);
        checkOutput("hit_lives", lives, 2);
        checkOutput("hit_flash0", flash, 0);
        applyStimulus(4);
        checkOutput("flash_4", flash, 1);
        applyStimulus(4);
        checkOutput("flash_8", flash, 0);
        passPulses(3);
        checkOutput("score_hit", score, 13);
        applyStimulus(23);
        checkOutput("invuln_state", state, 2);
        checkOutput("invuln_lives", lives, 2);
        checkOutput("invuln_flash", flash, 1);
        lava_x = 10'd500;
        applyStimulus(1);
        checkOutput("hitend_state", state, 1);
        checkOutput("hitend_flash", flash, 0);
        checkOutput("hitend_lives", lives, 2);

        // Second hit, then wait out invulnerability clear of obstacles.
        lava_x = 10'd110;
        applyStimulus(4);
        checkOutput("hit2_state", state, 2);
        checkOutput("hit2_lives", lives, 1);
        lava_x = 10'd500;
        applyStimulus(32);
        checkOutput("hit2end_state", state, 1);

        // Final hit on mountain2 with a coincident obstacle pass.
        mountain2_x = 10'd120; mountain2_y = 10'd150;
        applyStimulus(3);
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
        obstacle_passed = 1'b1;
        cyc();
        obstacle_passed = 1'b0;
        cyc();
        checkOutput("over_state", state, 3);
        checkOutput("over_gameover", game_over, 1);
        checkOutput("over_lives", lives, 0);
        checkOutput("over_score", score, 14);
        stepCount = 0;
        applyStimulus(10);
        checkOutput("over_nostep", stepCount, 0);
        passPulses(5);
        checkOutput("over_score_held", score, 14);

        pressStart();
        checkOutput("over_to_idle", state, 0);
        checkOutput("idle_gameover", game_over, 1);
        passPulses(2);
        checkOutput("idle_score_held", score, 14);
        mountain2_x = 10'd800;
        pressStart();
        checkOutput("restart_state", state, 1);
        checkOutput("restart_score", score, 0);
        checkOutput("restart_lives", lives, 3);

        passPulses(300);
        checkOutput("score_sat", score, 255);

        lava_x = 10'd110;
        applyStimulus(4);
        checkOutput("g2_hit_state", state, 2);

        // Reset wins over a coincident tick and pass.
        reset = 1'b1; frame_tick = 1'b1; obstacle_passed = 1'b1;
        cyc();
        reset = 1'b0; frame_tick = 1'b0; obstacle_passed = 1'b0;
        checkOutput("midreset_state", state, 0);
        checkOutput("midreset_score", score, 0);
        checkOutput("midreset_lives", lives, 0);
        checkOutput("midreset_gameover", game_over, 1);
        checkOutput("midreset_flash", flash, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
